// File: rtl/stream_transpose_buf.sv
// stream_transpose_buf: ping-pong matrix buffer that streams NUM_PE x NUM_PE matrices
// back out one row per beat, either transposed or unchanged, with valid/ready on both sides.
module stream_transpose_buf #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_PE     = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic                                 in_mode,
    input  logic [NUM_PE-1:0][DATA_WIDTH-1:0]    in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [NUM_PE-1:0][DATA_WIDTH-1:0]    out_data,
    output logic                                 out_last,
    output logic                                 out_mode,
    output logic [CNT_WIDTH-1:0]                 mat_count
);
    localparam int RW = $clog2(NUM_PE);
    localparam logic [RW-1:0] LAST = RW'(NUM_PE - 1);

    logic [NUM_PE-1:0][DATA_WIDTH-1:0] bank_q [2][NUM_PE];
    logic [1:0]           full_q, full_d, mode_q, mode_d;
    logic                 wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [RW-1:0]        wr_row_q, wr_row_d, rd_row_q, rd_row_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 accept, fire, wr_last, rd_last;

    assign in_ready  = rst_n && !full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;
    assign wr_last   = wr_row_q == LAST;
    assign rd_last   = rd_row_q == LAST;
    assign out_last  = out_valid && rd_last;
    assign out_mode  = mode_q[rd_bank_q];
    assign mat_count = cnt_q;

    always_comb begin
        full_d = full_q;
        mode_d = mode_q;
        if (accept && wr_row_q == '0) mode_d[wr_bank_q] = in_mode;
        if (accept && wr_last) full_d[wr_bank_q] = 1'b1;
        // the two banks touched here always differ, so set and clear never collide
        if (fire && rd_last) full_d[rd_bank_q] = 1'b0;
        wr_bank_d = wr_bank_q ^ (accept && wr_last);
        rd_bank_d = rd_bank_q ^ (fire && rd_last);
        wr_row_d  = accept ? (wr_last ? '0 : wr_row_q + 1'b1) : wr_row_q;
        rd_row_d  = fire ? (rd_last ? '0 : rd_row_q + 1'b1) : rd_row_q;
        cnt_d     = cnt_q + CNT_WIDTH'(fire && rd_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= '0;
            mode_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_row_q  <= '0;
            rd_row_q  <= '0;
            cnt_q     <= '0;
        end else begin
            full_q    <= full_d;
            mode_q    <= mode_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_row_q  <= wr_row_d;
            rd_row_q  <= rd_row_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) bank_q[wr_bank_q][wr_row_q] <= in_data;
    end

    for (genvar k = 0; k < NUM_PE; k++) begin : g_col
        assign out_data[k] = !out_valid ? '0 :
                             mode_q[rd_bank_q] ? bank_q[rd_bank_q][k][rd_row_q]
                                               : bank_q[rd_bank_q][rd_row_q][k];
    end
endmodule

// File: tb/tb_stream_transpose_buf.sv
// tb_stream_transpose_buf: scoreboard bench for stream_transpose_buf at NUM_PE=4, DATA_WIDTH=8.
module tb_stream_transpose_buf;
    typedef logic [3:0][7:0] row_t;
    typedef row_t mat_t [4];
    typedef struct {row_t d; logic l; logic m;} exp_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, out_last, out_mode;
    row_t in_data = '0, out_data;
    logic [15:0] mat_count, exp_cnt = '0;
    int checks = 0, failures = 0, cyc = 0;
    exp_t q[$];

    stream_transpose_buf #(.DATA_WIDTH(8), .NUM_PE(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_mode(out_mode), .mat_count(mat_count));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic monitor();
        logic pv = 1'b0, pr = 1'b0, pl = 1'b0, pm = 1'b0;
        row_t pd = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) pv = 1'b0;
            else begin
                if (pv && !pr) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl || out_mode !== pm) begin
                        failures++;
                        $display("FAIL hold: got v=%b d=%h l=%b m=%b want v=1 d=%h l=%b m=%b",
                                 out_valid, out_data, out_last, out_mode, pd, pl, pm);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_row: got d=%h want no output", out_data);
                    end else begin
                        e = q.pop_front();
                        if (out_data !== e.d) begin
                            failures++;
                            $display("FAIL out_data: got %h want %h", out_data, e.d);
                        end
                        checks++;
                        if (out_last !== e.l) begin
                            failures++;
                            $display("FAIL out_last: got %b want %b", out_last, e.l);
                        end
                        checks++;
                        if (out_mode !== e.m) begin
                            failures++;
                            $display("FAIL out_mode: got %b want %b", out_mode, e.m);
                        end
                        if (e.l) exp_cnt++;
                    end
                end
                pv = out_valid; pr = out_ready; pd = out_data; pl = out_last; pm = out_mode;
            end
        end
    endtask

    function automatic mat_t rand_mat();
        mat_t m;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) m[r][k] = 8'($urandom);
        return m;
    endfunction

    task automatic push_exp(input mat_t m, input logic md);
        row_t e;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) e[k] = md ? m[k][r] : m[r][k];
            q.push_back('{e, r == 3, md});
        end
    endtask

    task automatic put_row(input row_t d, input logic md);
        logic acc = 1'b0;
        int n = 0;
        in_valid = 1'b1; in_data = d; in_mode = md;
        do begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1; n++;
        end while (!acc && n < 300);
        if (!acc) begin
            checks++; failures++;
            $display("FAIL put_row_timeout: got in_ready=0 for %0d cycles want 1", n);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_matrix(input mat_t m, input logic md, input logic tog);
        push_exp(m, md);
        for (int r = 0; r < 4; r++) put_row(m[r], (tog && r != 0) ? ~md : md);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin @(posedge clk); n++; end
        @(posedge clk); #1;
        if (q.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout: got %0d rows pending want 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        #3;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL rst_out_data: got %h want 0", out_data); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL rst_out_last: got %b want 0", out_last); end
        checks++; if (out_mode !== 1'b0) begin failures++; $display("FAIL rst_out_mode: got %b want 0", out_mode); end
        checks++; if (mat_count !== '0) begin failures++; $display("FAIL rst_mat_count: got %0d want 0", mat_count); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_transpose(input logic md);
        mat_t m;
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) m[r][k] = 8'(r * 4 + k);
        out_ready = 1'b1;
        push_exp(m, md);
        for (int r = 0; r < 3; r++) put_row(m[r], md);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL early_valid: got %b want 0", out_valid); end
        put_row(m[3], md);
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL latency_valid: got %b want 1", out_valid); end
        wait_drain();
        checks++;
        if (mat_count !== exp_cnt) begin failures++; $display("FAIL mat_count_single: got %0d want %0d", mat_count, exp_cnt); end
    endtask

    task automatic test_backpressure();
        mat_t m1 = rand_mat(), m2 = rand_mat(), m3 = rand_mat();
        int c0;
        out_ready = 1'b0;
        c0 = cyc;
        send_matrix(m1, 1'b1, 1'b0);
        send_matrix(m2, 1'b0, 1'b0);
        checks++;
        if (cyc - c0 !== 8) begin failures++; $display("FAIL bp_fill_cycles: got %0d want 8", cyc - c0); end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_full: got %b want 0", in_ready); end
        @(posedge clk); #1;
        fork
            send_matrix(m3, 1'b1, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
                repeat (3) @(posedge clk);
                @(negedge clk);
                checks++;
                if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_mid: got %b want 0", in_ready); end
                @(negedge clk);
                checks++;
                if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_return: got %b want 1", in_ready); end
            end
        join
        wait_drain();
        checks++;
        if (mat_count !== exp_cnt) begin failures++; $display("FAIL bp_mat_count: got %0d want %0d", mat_count, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        int c0;
        logic [15:0] n0 = mat_count;
        out_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 10; i++) send_matrix(rand_mat(), 1'(i % 2), 1'b1);
        checks++;
        if (cyc - c0 !== 40) begin failures++; $display("FAIL b2b_cycles: got %0d want 40", cyc - c0); end
        wait_drain();
        checks++;
        if (mat_count !== 16'(n0 + 10)) begin failures++; $display("FAIL b2b_mat_count: got %0d want %0d", mat_count, 16'(n0 + 10)); end
    endtask

    task automatic test_random_stall();
        logic done = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send_matrix(rand_mat(), 1'($urandom % 2), 1'b0);
                done = 1'b1;
            end
            while (!done) begin @(posedge clk); #1 out_ready = 1'($urandom % 2); end
        join
        out_ready = 1'b1;
        wait_drain();
        checks++;
        if (mat_count !== exp_cnt) begin failures++; $display("FAIL rand_mat_count: got %0d want %0d", mat_count, exp_cnt); end
    endtask

    task automatic test_reset_midstream();
        mat_t a = rand_mat(), b = rand_mat();
        out_ready = 1'b0;
        send_matrix(a, 1'b1, 1'b0);
        put_row(b[0], 1'b0);
        put_row(b[1], 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL mid_rst_out_data: got %h want 0", out_data); end
        checks++; if (out_mode !== 1'b0) begin failures++; $display("FAIL mid_rst_out_mode: got %b want 0", out_mode); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_in_ready: got %b want 0", in_ready); end
        checks++; if (mat_count !== '0) begin failures++; $display("FAIL mid_rst_mat_count: got %0d want 0", mat_count); end
        q.delete();
        exp_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_matrix(rand_mat(), 1'b1, 1'b0);
        wait_drain();
        checks++;
        if (mat_count !== 16'd1) begin failures++; $display("FAIL post_rst_mat_count: got %0d want 1", mat_count); end
    endtask

    initial begin
        fork monitor(); join_none
        test_reset();
        test_transpose(1'b1);
        test_transpose(1'b0);
        test_backpressure();
        test_back_to_back();
        test_random_stall();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stream_transpose_buf.md
Name: stream_transpose_buf

Overview:
- Parametrised successor to the fixed switch-network transposer.
- Accepts an NUM_PE x NUM_PE matrix streamed one row per beat over a valid/ready handshake.
- Stores each matrix in one of two ping-pong banks and streams it back out one row per beat: transposed (columns of the input) or unmodified, selected per matrix.
- Sits between the PE array and the memory groups. Replaces the lock-step valid shift chain with real back-pressure and sustains one beat per cycle.

Parameters:
- DATA_WIDTH, 64, width of one matrix element.
- NUM_PE, 8, matrix dimension: elements per row and rows per matrix (>=2).
- CNT_WIDTH, 16, width of the completed-matrix counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input row beat valid.
- in_ready  out  1  block can accept an input row.
- in_mode  in  1  1 = transpose, 0 = pass-through; sampled on the first row of each matrix.
- in_data  in  NUM_PE x DATA_WIDTH  input row, element k = column k.
- out_valid  out  1  output row beat valid.
- out_ready  in  1  downstream accepts the output row.
- out_data  out  NUM_PE x DATA_WIDTH  output row, element k.
- out_last  out  1  current output row is the final row of its matrix.
- out_mode  out  1  mode latched for the matrix currently draining.
- mat_count  out  CNT_WIDTH  number of matrices fully drained, wrapping.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While rst_n = 0: in_ready=0, out_valid=0, out_last=0, out_mode=0, mat_count=0, out_data=0.
  - Both bank-full flags cleared; wr_bank=rd_bank=0; wr_row=rd_row=0.
  - Bank storage is not reset.
- Reset mid-matrix discards all partially written and undrained data. After deassertion the block starts empty.
- Storage: two banks of NUM_PE x NUM_PE elements. Each bank has a full flag and a mode bit.
- Write side:
  - in_ready = !full[wr_bank] and not in reset. It is a function of registered state only, never of out_ready.
  - Accept when in_valid && in_ready: write in_data to row wr_row of bank wr_bank.
  - If wr_row==0, latch in_mode into mode[wr_bank]. in_mode on later rows is ignored.
  - If wr_row==NUM_PE-1: set full[wr_bank], toggle wr_bank, wr_row=0. Otherwise wr_row++.
- Read side:
  - out_valid = full[rd_bank].
  - out_data[k] = bank[rd_bank][k][rd_row] when mode[rd_bank]=1; bank[rd_bank][rd_row][k] when 0.
  - out_data is forced to 0 while out_valid=0.
  - out_last = out_valid && rd_row==NUM_PE-1. out_mode = mode[rd_bank].
  - Fire when out_valid && out_ready: if rd_row==NUM_PE-1, clear full[rd_bank], toggle rd_bank, rd_row=0, mat_count++ (wraps at 2^CNT_WIDTH). Otherwise rd_row++.
- Holding rules:
  - out_data, out_last and out_mode hold stable while out_valid=1 and out_ready=0.
  - in_data is ignored when not accepted.
- Latency: the last row of a matrix is accepted at edge t; out_valid=1 with row 0 is visible after edge t.
- Throughput: with in_valid and out_ready held high, the block sustains one beat per cycle on both sides indefinitely.
  - A bank cleared at edge t is writable immediately after edge t.
  - A bank cannot be both set full and cleared at the same edge, because its write and read pointers differ.
- Full: both banks full gives in_ready=0 until the current drain completes.
- Empty: out_valid=0. No read pointer movement.
- Simultaneous accept and fire in one cycle is legal and independent.
- Row and bank pointers wrap modulo NUM_PE and modulo 2 respectively.

Test Plan:
- NUM_PE=4, DATA_WIDTH=8, mode=1. Input rows {0,1,2,3},{4,5,6,7},{8,9,10,11},{12,13,14,15}, out_ready=1.
  -> out_valid rises the cycle after the 4th accept.
  -> Rows {0,4,8,12},{1,5,9,13},{2,6,10,14},{3,7,11,15}.
  -> out_last on the 4th row; mat_count=1.
- Same input with mode=0 -> output rows identical to input; out_mode=0.
- Back-pressure: out_ready=0, stream 3 matrices.
  -> in_ready drops after 8 accepts; 9th row stalls.
  -> Raising out_ready drains matrix 1 and in_ready returns the cycle after its last fire.
  -> Order of all 3 matrices preserved.
- Continuous stream of 10 matrices, in_valid=out_ready=1, alternating modes (mode toggled mid-matrix ignored).
  -> 40 input beats in 40 cycles, no in_ready gaps.
  -> Correct per-matrix mode; mat_count=10.
- Random out_ready stalls (50%).
  -> out_data stable across every stall cycle.
  -> Scoreboard matches the reference transpose.
- Assert rst_n low after 2 rows of matrix 1 plus one full buffered matrix.
  -> Outputs zero immediately (asynchronous); mat_count=0.
  -> The next complete matrix after release is output correctly with no stale rows.
